future_round_ctrl: RTL and testbench

Round sequencer for the FUTURE block-cipher encryption datapath. It accepts one block request through a valid/ready handshake and drives the external state register, AddRoundKey, and round-function enables. It issues one whitening cycle, then NUM_ROUNDS round cycles, then presents the result with output backpressure. It sits between the block-level I/O interface and the combinational round logic; this block carries no data, only control.

---
 rtl/future_round_ctrl_if.sv | 31 +++
 rtl/future_round_ctrl.sv | 90 +++++++++
 tb/tb_future_round_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/future_round_ctrl_if.sv
// Control bundle between the FUTURE round sequencer and its surroundings.
// The block-level I/O side uses the master modport; the sequencer uses the slave modport.
interface future_round_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic             ld_state;
    logic             ark_en;
    logic             rnd_en;
    logic [3:0]       rnd_idx;
    logic             key_sel;
    logic             mc_bypass;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic [CNT_W-1:0] blk_cnt;

    modport slave (
        input  in_valid, flush, out_ready,
        output in_ready, ld_state, ark_en, rnd_en, rnd_idx, key_sel,
               mc_bypass, out_valid, busy, blk_cnt
    );

    modport master (
        output in_valid, flush, out_ready,
        input  in_ready, ld_state, ark_en, rnd_en, rnd_idx, key_sel,
               mc_bypass, out_valid, busy, blk_cnt
    );
endinterface

// File: rtl/future_round_ctrl.sv
// FUTURE round sequencer: one whitening cycle, NUM_ROUNDS round cycles, then a held result.
// Control only; the datapath enables are decoded from the state and round index.
module future_round_ctrl #(
    parameter int NUM_ROUNDS = 10,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    future_round_ctrl_if.slave  ctrl
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_WHITEN,
        S_ROUND,
        S_DONE
    } state_e;

    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

    state_e           state_q, state_d;
    logic [3:0]       rnd_idx_q, rnd_idx_d;
    logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        rnd_idx_d = rnd_idx_q;
        blk_cnt_d = blk_cnt_q;
        if (ctrl.flush) begin
            state_d   = S_IDLE;
            rnd_idx_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (ctrl.in_valid) state_d = S_WHITEN;
                end
                S_WHITEN: begin
                    state_d   = S_ROUND;
                    rnd_idx_d = 4'd1;
                end
                S_ROUND: begin
                    if (rnd_idx_q < LAST_RND) begin
                        rnd_idx_d = rnd_idx_q + 4'd1;
                    end else begin
                        state_d   = S_DONE;
                        rnd_idx_d = '0;
                    end
                end
                S_DONE: begin
                    if (ctrl.out_ready) begin
                        state_d = S_IDLE;
                        if (!(&blk_cnt_q)) blk_cnt_d = blk_cnt_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rnd_idx_q <= '0;
            blk_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rnd_idx_q <= rnd_idx_d;
            blk_cnt_q <= blk_cnt_d;
        end
    end

    logic st_idle, st_whiten, st_round, st_done;
    assign st_idle   = (state_q == S_IDLE);
    assign st_whiten = (state_q == S_WHITEN);
    assign st_round  = (state_q == S_ROUND);
    assign st_done   = (state_q == S_DONE);

    // ld_state is masked during reset so every output shows its reset value while rst is high.
    assign ctrl.in_ready  = st_idle;
    assign ctrl.ld_state  = st_idle & ctrl.in_valid & ~ctrl.flush & ~rst;
    assign ctrl.ark_en    = st_whiten & ~ctrl.flush;
    assign ctrl.rnd_en    = st_round & ~ctrl.flush;
    assign ctrl.rnd_idx   = rnd_idx_q;
    assign ctrl.key_sel   = st_round & ~rnd_idx_q[0];
    assign ctrl.mc_bypass = st_round & (rnd_idx_q == LAST_RND);
    assign ctrl.out_valid = st_done & ~ctrl.flush;
    assign ctrl.busy      = ~st_idle;
    assign ctrl.blk_cnt   = blk_cnt_q;
endmodule

// File: tb/tb_future_round_ctrl.sv
// Self-checking bench for future_round_ctrl: cycle model of the control outputs plus a
// scoreboard of accepted blocks checked for latency and completion count.
module tb_future_round_ctrl;
    localparam int NR  = 10;
    localparam int CW  = 2;
    localparam int LAT = NR + 2;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    future_round_ctrl_if #(.CNT_W(CW)) bus ();

    future_round_ctrl #(.NUM_ROUNDS(NR), .CNT_W(CW)) dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int acc;
        int exp_cnt;
    } sb_t;

    sb_t sb_q[$];
    int  cyc = 0;
    bit  m_busy = 1'b0;
    int  m_k = 0;
    int  m_cnt = 0;
    bit  prev_ov = 1'b0;
    bit  pend = 1'b0;
    int  pend_val = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: m_k counts cycles since acceptance (1 = whitening, 2..NR+1 = rounds).
    always @(negedge clk) begin : monitor
        bit e_round;
        bit e_whiten;
        bit e_done;
        int n_en;
        if (rst) begin
            m_busy = 1'b0;
            m_k    = 0;
            m_cnt  = 0;
            sb_q.delete();
            pend    = 1'b0;
            prev_ov = 1'b0;
        end
        e_whiten = m_busy && (m_k == 1);
        e_round  = m_busy && (m_k >= 2) && (m_k <= NR + 1);
        e_done   = m_busy && (m_k == NR + 2);

        check("in_ready",  bus.in_ready,  !m_busy);
        check("ld_state",  bus.ld_state,  !rst && !m_busy && bus.in_valid && !bus.flush);
        check("ark_en",    bus.ark_en,    e_whiten && !bus.flush);
        check("rnd_en",    bus.rnd_en,    e_round && !bus.flush);
        check("rnd_idx",   bus.rnd_idx,   e_round ? m_k - 1 : 0);
        check("key_sel",   bus.key_sel,   e_round && ((m_k - 1) % 2 == 0));
        check("mc_bypass", bus.mc_bypass, e_round && (m_k - 1 == NR));
        check("out_valid", bus.out_valid, e_done && !bus.flush);
        check("busy",      bus.busy,      m_busy);
        check("blk_cnt",   bus.blk_cnt,   m_cnt);
        n_en = int'(bus.ld_state) + int'(bus.ark_en) + int'(bus.rnd_en);
        check("enable_onehot", n_en <= 1, 1);

        if (pend) begin
            check("sb_blk_cnt", bus.blk_cnt, pend_val);
            pend = 1'b0;
        end
        if (bus.out_valid && !prev_ov) begin
            if (sb_q.size() == 0) check("sb_spurious_out", 1, 0);
            else                  check("sb_latency", cyc - sb_q[0].acc, LAT);
        end
        if (bus.out_valid && bus.out_ready && sb_q.size() > 0) begin
            pend     = 1'b1;
            pend_val = sb_q[0].exp_cnt;
            void'(sb_q.pop_front());
        end
        prev_ov = bus.out_valid;

        if (!rst) begin
            if (bus.flush) begin
                if (m_busy) sb_q.delete();
                m_busy = 1'b0;
                m_k    = 0;
            end else if (!m_busy) begin
                if (bus.in_valid) begin
                    m_busy = 1'b1;
                    m_k    = 1;
                    sb_q.push_back('{acc: cyc, exp_cnt: (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX});
                end
            end else if (m_k <= NR + 1) begin
                m_k++;
            end else if (bus.out_ready) begin
                m_busy = 1'b0;
                m_k    = 0;
                if (m_cnt < CNT_MAX) m_cnt++;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int max_cyc);
        int i = 0;
        while (!bus.in_ready && i < max_cyc) begin
            tick();
            i++;
        end
        check("wait_in_ready_bound", bus.in_ready, 1);
    endtask

    task automatic wait_valid(input int max_cyc);
        int i = 0;
        while (!bus.out_valid && i < max_cyc) begin
            tick();
            i++;
        end
        check("wait_out_valid_bound", bus.out_valid, 1);
    endtask

    task automatic send_block();
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_busy", bus.busy, 0);
        check("reset_rnd_idx", bus.rnd_idx, 0);
        check("reset_blk_cnt", bus.blk_cnt, 0);
        tick(2);
        rst = 1'b0;
        tick();

        // Single block, consumer always ready.
        bus.out_ready = 1'b1;
        send_block();
        wait_ready(40);
        check("single_blk_cnt", bus.blk_cnt, 1);

        // Backpressure: result held for 5 cycles, handshake on the 6th.
        bus.out_ready = 1'b0;
        send_block();
        wait_valid(40);
        repeat (5) begin
            check("bp_out_valid_held", bus.out_valid, 1);
            check("bp_rnd_en_low", bus.rnd_en, 0);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        check("bp_blk_cnt", bus.blk_cnt, 2);
        wait_ready(40);

        // Flush in round 4 aborts the block without counting it.
        send_block();
        tick(4);
        check("flush_at_round4_idx", bus.rnd_idx, 4);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_busy", bus.busy, 0);
        check("flush_rnd_idx", bus.rnd_idx, 0);
        check("flush_blk_cnt", bus.blk_cnt, 2);

        // Flush together with in_valid in IDLE: not accepted.
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        check("flush_idle_not_accepted", bus.busy, 0);

        // Flush together with out_ready in DONE: no completion counted.
        bus.out_ready = 1'b0;
        send_block();
        wait_valid(40);
        tick();
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_done_blk_cnt", bus.blk_cnt, 2);
        check("flush_done_in_ready", bus.in_ready, 1);

        // Full-latency block after the flushes; counter reaches 3.
        send_block();
        wait_ready(40);
        check("post_flush_blk_cnt", bus.blk_cnt, 3);

        // Back-to-back: three blocks with in_valid held high; counter stays saturated.
        bus.in_valid = 1'b1;
        tick(3 * (NR + 3) - 12);
        bus.in_valid = 1'b0;
        wait_ready(40);
        check("b2b_blk_cnt_saturated", bus.blk_cnt, CNT_MAX);

        // Asynchronous reset in the middle of a round, between clock edges.
        send_block();
        tick(4);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_rnd_en", bus.rnd_en, 0);
        check("arst_rnd_idx", bus.rnd_idx, 0);
        check("arst_in_ready", bus.in_ready, 1);
        check("arst_blk_cnt", bus.blk_cnt, 0);
        tick();
        rst = 1'b0;
        tick();

        send_block();
        wait_ready(40);
        check("after_arst_blk_cnt", bus.blk_cnt, 1);
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
